mux_rr_chan: RTL and testbench
==============================

// Module: mux_rr_chan
// PURPOSE
//  Parametrised N-channel multiplexer with a registered output and valid/ready handshaking.
//  It generalises the 4:1 select mux to 2**SW channels of W-bit data.
//  Two arbitration modes are supported:
//   - fixed-select: the sel input chooses the channel;
//   - round-robin: fair arbitration across channels.
//  It sits between several producer channels and a single downstream consumer.
// PARAMETERS
//  W   8  data width per channel, in bits
//  SW  2  select width; channel count N = 2**SW
// PORTS
//  clk        in   1     system clock; all logic is on the rising edge
//  rst        in   1     synchronous reset, active-high
//  in_data    in   N*W   channel k occupies bits [k*W +: W]
//  in_valid   in   N     channel k presents a word
//  in_ready   out  N     channel k's word is accepted this cycle
//  mode       in   1     0 = fixed-select, 1 = round-robin
//  sel        in   SW    channel select, used only when mode = 0
//  out_data   out  W     registered output word
//  out_chan   out  SW    index of the channel that supplied out_data
//  out_valid  out  1     output register holds a valid word
//  out_ready  in   1     consumer accepts out_data this cycle
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_chan=0, rr pointer ptr=0. in_ready is all-zero while rst=1.
//  Output register states:
//   - EMPTY (out_valid=0) and FULL (out_valid=1).
//   - load_en = !out_valid || out_ready (the register is free or being drained this cycle).
//  Grant (combinational):
//   - mode=0: grant=sel if in_valid[sel]; otherwise no grant. Other channels are never granted.
//   - mode=1: grant = first k with in_valid[k]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wraps mod N).
//     No grant if in_valid is all zero.
//  in_ready[k] = load_en && grant valid && grant==k. At most one bit is high; the result is one-hot or zero.
//  Transfer on channel k = in_valid[k] && in_ready[k]. On the next edge:
//   - out_data <= in_data[k*W +: W]
//   - out_chan <= k
//   - out_valid <= 1
//  Drain: if out_valid && out_ready with no new transfer, out_valid <= 0.
//   out_data and out_chan hold their last values.
//  Stall: while out_valid && !out_ready, out_data and out_chan are stable and all in_ready=0.
//  Latency is 1 cycle from input accept to out_valid. Simultaneous drain and load gives full throughput of 1 word per cycle.
//  Round-robin pointer:
//   - On a transfer with mode=1, ptr <= (grant+1) mod N; N-1 wraps to 0.
//   - With no transfer, or with mode=0, ptr holds.
//  Mode or sel changes take effect in the same cycle.
//   - An already-registered word is unaffected.
//   - ptr is retained across mode switches.
//  Reset asserted mid-operation discards any held word. out_valid is 0 on the cycle after rst.
//  There is no default or X output: when nothing is valid, the output register simply does not load.
// TESTING
//  1. mode=0, sel=2, in_valid=4'b1111, ch2=8'hA5, out_ready=1
//     -> only in_ready[2]=1; next cycle out_data=A5, out_chan=2, out_valid=1.
//  2. mode=0, sel=1, in_valid=4'b1101 -> in_ready=0000; out_valid stays 0 (no fallback to other channels).
//  3. mode=1, all channels valid, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3, one word per cycle.
//  4. mode=1, in_valid=4'b1001, ptr=1 -> grant 3, then ptr=0 -> grant 0 (wrap-around skip of idle channels).
//  5. out_valid=1, out_ready=0 for 3 cycles with inputs valid
//     -> out_data/out_chan constant, in_ready=0000; out_ready=1 -> drain and reload in the same cycle.
//  6. rst pulsed while out_valid=1 and ptr=2 -> next cycle out_valid=0, out_data=0, ptr=0; the first RR grant goes to ch0.

Source files
------------

// File: rtl/mux_rr_chan.sv
// N-channel registered multiplexer with valid/ready handshaking.
// Grants by fixed select or by round-robin rotation.
module mux_rr_chan #(
  parameter int W  = 8,
  parameter int SW = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [(2**SW)*W-1:0]  in_data,
  input  logic [(2**SW)-1:0]    in_valid,
  output logic [(2**SW)-1:0]    in_ready,
  input  logic                  mode,
  input  logic [SW-1:0]         sel,
  output logic [W-1:0]          out_data,
  output logic [SW-1:0]         out_chan,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int N = 2**SW;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [W-1:0]    r_data;
  logic [SW-1:0]   r_chan;
  logic [SW-1:0]   r_ptr;

  logic            w_loadEn;
  logic            w_grantValid;
  logic [SW-1:0]   w_grant;
  logic [SW-1:0]   w_idx;
  logic            w_xfer;

  assign w_loadEn = (r_state == EMPTY) || out_ready;

  // Round-robin scans ptr, ptr+1, ... with SW-bit arithmetic providing the wrap.
  always_comb begin
    w_grant      = '0;
    w_grantValid = 1'b0;
    w_idx        = '0;
    if (!mode) begin
      w_grant      = sel;
      w_grantValid = in_valid[sel];
    end else begin
      for (int i = 0; i < N; i++) begin
        w_idx = r_ptr + SW'(i);
        if (!w_grantValid && in_valid[w_idx]) begin
          w_grant      = w_idx;
          w_grantValid = 1'b1;
        end
      end
    end
  end

  assign w_xfer   = !rst && w_loadEn && w_grantValid;
  assign in_ready = w_xfer ? (N'(1) << w_grant) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    if (w_xfer) begin
      w_stateNext = FULL;
    end else if (r_state == FULL && out_ready) begin
      w_stateNext = EMPTY;
    end
  end

  // Data and channel hold their last values on drain; only a transfer reloads them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_chan <= '0;
      r_ptr  <= '0;
    end else if (w_xfer) begin
      r_data <= in_data[w_grant*W +: W];
      r_chan <= w_grant;
      if (mode) begin
        r_ptr <= w_grant + SW'(1);
      end
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = (r_state == FULL);

endmodule

// File: tb/tb_mux_rr_chan.sv
// Self-checking bench for mux_rr_chan: directed scenarios plus randomized
// traffic compared against an abstract arbitration model.
module tb_mux_rr_chan;

  localparam int W  = 8;
  localparam int SW = 2;
  localparam int N  = 4;

  logic             clk;
  logic             rst;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic             mode;
  logic [SW-1:0]    sel;
  logic [W-1:0]     out_data;
  logic [SW-1:0]    out_chan;
  logic             out_valid;
  logic             out_ready;

  int checks;
  int failures;

  int mVal;
  int mData;
  int mChan;
  int mPtr;

  mux_rr_chan #(.W(W), .SW(SW)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode(mode),
    .sel(sel),
    .out_data(out_data),
    .out_chan(out_chan),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int modelGrant(input int m, input int s, input logic [N-1:0] v, input int p);
    if (m == 0) begin
      return v[s] ? s : -1;
    end
    for (int off = 0; off < N; off++) begin
      if (v[(p + off) % N]) return (p + off) % N;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, advance model, check outputs.
  task automatic applyStimulus(input logic r, input logic m, input logic [SW-1:0] s,
                               input logic [N-1:0] v, input logic ordy, input logic [N*W-1:0] d);
    int g;
    logic [N-1:0] expReady;
    bit loadEn;
    rst = r; mode = m; sel = s; in_valid = v; out_ready = ordy; in_data = d;
    #1;
    g = modelGrant(int'(m), int'(s), v, mPtr);
    loadEn = (mVal == 0) || ordy;
    expReady = '0;
    if (!r && loadEn && g >= 0) expReady[g] = 1'b1;
    checkOutput("in_ready", 32'(in_ready), 32'(expReady));
    @(posedge clk);
    if (r) begin
      mVal = 0; mData = 0; mChan = 0; mPtr = 0;
    end else if (loadEn && g >= 0) begin
      mVal  = 1;
      mData = int'(d[g*W +: W]);
      mChan = g;
      if (m) mPtr = (g + 1) % N;
    end else if (mVal != 0 && ordy) begin
      mVal = 0;
    end
    #1;
    checkOutput("out_valid", 32'(out_valid), 32'(mVal));
    checkOutput("out_data", 32'(out_data), 32'(mData));
    checkOutput("out_chan", 32'(out_chan), 32'(mChan));
  endtask

  initial begin
    logic [N*W-1:0] d;
    checks = 0; failures = 0;
    mVal = 0; mData = 0; mChan = 0; mPtr = 0;
    d = {8'h44, 8'hA5, 8'h22, 8'h11};

    // Reset state
    applyStimulus(1'b1, 1'b0, 2'd0, 4'b1111, 1'b1, d);
    checkOutput("rst_ready", 32'(in_ready), 32'h0);
    checkOutput("rst_valid", 32'(out_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, d);

    // Fixed select of channel 2
    applyStimulus(1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, d);
    checkOutput("t1_data", 32'(out_data), 32'hA5);
    checkOutput("t1_chan", 32'(out_chan), 32'd2);

    // Selected channel idle: no fallback, output drains
    applyStimulus(1'b0, 1'b0, 2'd1, 4'b1101, 1'b1, d);
    checkOutput("t2_valid", 32'(out_valid), 32'h0);
    checkOutput("t2_chan_hold", 32'(out_chan), 32'd2);

    // Round-robin over all channels from ptr=0
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, d);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, d);
      checkOutput("t3_chan", 32'(out_chan), 32'(i % N));
      checkOutput("t3_valid", 32'(out_valid), 32'h1);
    end

    // Wrap-around skip: ptr=1, channels 3 and 0 valid
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, d);
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, d);
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b1001, 1'b1, d);
    checkOutput("t4_chan3", 32'(out_chan), 32'd3);
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b1001, 1'b1, d);
    checkOutput("t4_chan0", 32'(out_chan), 32'd0);

    // Stall for three cycles, then drain and reload together
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, d);
      checkOutput("t5_stall_data", 32'(out_data), 32'h11);
      checkOutput("t5_stall_ready", 32'(in_ready), 32'h0);
    end
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, d);
    checkOutput("t5_reload_chan", 32'(out_chan), 32'd1);
    checkOutput("t5_reload_valid", 32'(out_valid), 32'h1);

    // Reset while full with ptr=2, then first RR grant goes to ch0
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, d);
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b0010, 1'b0, d);
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, d);
    checkOutput("t6_valid", 32'(out_valid), 32'h0);
    checkOutput("t6_data", 32'(out_data), 32'h0);
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, d);
    checkOutput("t6_chan", 32'(out_chan), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 31) == 0),
                    1'($urandom),
                    SW'($urandom),
                    N'($urandom),
                    ($urandom_range(0, 9) < 7),
                    {$urandom, $urandom} >> 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
